mdu: RTL and testbench

Multiply/divide unit in the EX stage; executes the decoder's `MDUOp`/`MDUStart` commands. It owns the HI and LO registers and runs mult/multu/div/divu as multi-cycle operations. It exposes `busy` so the hazard unit can stall dependent md/mt/mf instructions in D. It also returns HI/LO for mfhi/mflo.

---
 rtl/mdu_pkg.sv | 81 ++++++++
 rtl/mdu.sv | 144 ++++++++++++++
 tb/tb_mdu.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e    : decoder operation codes carried to EX on MDUOp
//   - mdu_state_e : idle/busy state of the unit's sequencer
//   - mdu_res_t   : 64-bit result plus a write-enable flag
//   - mdu_calc()  : behavioural arithmetic for mult/multu/div/divu
//   - mdu_is_div(): selects the divide latency for an operation
package mdu_pkg;

  // Operation codes. The values match the decoder's MDUOp encoding.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTLO  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MFLO  = 3'd6,
    MDU_MFHI  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Width of the busy countdown. Cycle counts up to 255 fit.
  localparam int CNT_W = 8;

  // wr=0 means "leave HI/LO untouched when the operation completes"
  // (divide by zero, or a non-arithmetic opcode).
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  function automatic logic mdu_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic mdu_res_t mdu_calc(input mdu_op_e op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    mdu_res_t           res;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        prod;
    logic [31:0]        b_nz;
    res  = '0;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    prod = '0;
    // A zero divisor is swapped for 1 so the divider never sees 0; the
    // result is discarded anyway because wr stays low in that case.
    b_nz = (b == 32'd0) ? 32'd1 : b;
    case (op)
      MDU_MULT: begin
        prod = sa * sb;
        res  = {1'b1, prod};
      end
      MDU_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        res  = {1'b1, prod};
      end
      MDU_DIV: begin
        // Signed '/' truncates toward zero and '%' takes the dividend's sign.
        res.wr = (b != 32'd0);
        res.lo = $signed(a) / $signed(b_nz);
        res.hi = $signed(a) % $signed(b_nz);
      end
      MDU_DIVU: begin
        res.wr = (b != 32'd0);
        res.lo = a / b_nz;
        res.hi = a % b_nz;
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu.sv
// mdu: multiply/divide unit living in the EX stage.
// Owns the HI/LO registers and executes mult/multu/div/divu as
// multi-cycle operations, plus single-cycle mthi/mtlo and mfhi/mflo reads.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset, clears all state
//   MDUOp    in   [2:0] operation code (mdu_op_e encoding)
//   MDUStart in   high for mult/multu/div/divu in EX
//   req      in   exception flush of EX; blocks a new start / mt this cycle
//   A, B     in   [31:0] forwarded rs / rt operands
//   busy     out  multi-cycle operation in progress
//   MDUOut   out  [31:0] HI for mfhi, LO for mflo, else 0
//   HI, LO   out  [31:0] current HI / LO registers
//
// Handshake: a start is taken on a rising edge where MDUStart=1, busy=0 and
// req=0. busy then stays high for exactly N cycles (N = MULT_CYCLES or
// DIV_CYCLES); on the edge that drops busy, HI/LO take the result, so the
// new values are visible in the first cycle busy reads 0, and a new start
// may be presented in that same cycle. Starts and mt writes presented while
// busy are dropped; req never cancels an operation already accepted.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDUOp,
  input  logic        MDUStart,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_wr;

  mdu_op_e          w_op;
  logic             w_accept;
  logic             w_mt_ok;
  logic             w_done;
  mdu_res_t         w_res;

  assign w_op     = mdu_op_e'(MDUOp);
  assign busy     = (r_state == ST_BUSY);
  assign w_accept = MDUStart & ~busy & ~req;
  assign w_mt_ok  = ~busy & ~req & ((w_op == MDU_MTHI) || (w_op == MDU_MTLO));
  assign w_res    = mdu_calc(w_op, A, B);

  // Sequencer: next state, countdown and completion strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = mdu_is_div(w_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        // The edge that takes the counter to 0 is the completion edge.
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Result is captured at acceptance so the operands may change freely
  // while the operation is counting down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else if (w_accept) begin
      r_pend_hi <= w_res.hi;
      r_pend_lo <= w_res.lo;
      r_pend_wr <= w_res.wr;
    end
  end

  // Completion only happens while busy and mt only while idle, so the two
  // writers never compete for HI/LO in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      if (r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (w_mt_ok) begin
      if (w_op == MDU_MTHI) r_hi <= A;
      else                  r_lo <= A;
    end
  end

  // Reads come from the architectural registers only, never from pending.
  always_comb begin
    MDUOut = '0;
    case (w_op)
      MDU_MFHI: MDUOut = r_hi;
      MDU_MFLO: MDUOut = r_lo;
      default:  MDUOut = '0;
    endcase
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed bench for the multiply/divide unit, with a behavioural
// reference model that is compared against the DUT on every cycle.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  MDUOp;
  logic        MDUStart;
  logic        req;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] MDUOut;
  logic [31:0] HI;
  logic [31:0] LO;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .MDUStart(MDUStart), .req(req),
    .A(A), .B(B), .busy(busy), .MDUOut(MDUOut), .HI(HI), .LO(LO)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Results are computed with plain 64-bit arithmetic and queued at
  // acceptance; the completion edge is remembered as an absolute edge number.
  logic [64:0] exp_q[$];   // {write_enable, hi, lo}
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          m_busy = 1'b0;
  longint      edge_no = 0;
  longint      m_done_at = 0;

  function automatic logic [64:0] model_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sq;
    int              sr;
    logic [64:0]     r;
    r = '0;
    case (op)
      3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); r = {1'b1, sp}; end
      3'd1: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); r = {1'b1, up}; end
      3'd2: if (b != 0) begin
              sq = $signed(a) / $signed(b);
              sr = $signed(a) % $signed(b);
              r  = {1'b1, sr, sq};
            end
      3'd3: if (b != 0) r = {1'b1, a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    logic [64:0] e;
    edge_no++;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; exp_q.delete();
    end else if (m_busy) begin
      if (edge_no == m_done_at) begin
        e = exp_q.pop_front();
        if (e[64]) begin m_hi = e[63:32]; m_lo = e[31:0]; end
        m_busy = 1'b0;
      end
    end else if (!req) begin
      if (MDUStart) begin
        exp_q.push_back(model_calc(MDUOp, A, B));
        m_busy    = 1'b1;
        m_done_at = edge_no + ((MDUOp == 3'd2 || MDUOp == 3'd3) ? DIV_C : MULT_C);
      end else if (MDUOp == 3'd5) m_hi = A;
      else if (MDUOp == 3'd4) m_lo = A;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [31:0] exp_out;
    if (chk_en) begin
      exp_out = (MDUOp == 3'd7) ? m_hi : (MDUOp == 3'd6) ? m_lo : 32'd0;
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("cyc_hi", HI, m_hi);
      chk("cyc_lo", LO, m_lo);
      chk("cyc_mduout", MDUOut, exp_out);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] post_op);
    MDUOp = op; MDUStart = 1'b1; A = a; B = b;
    tick();
    MDUStart = 1'b0; MDUOp = post_op; A = 32'h0BAD_0BAD; B = 32'h0000_0003;
  endtask

  task automatic mt_op(input logic [2:0] op, input logic [31:0] v);
    MDUOp = op; A = v;
    tick();
    MDUOp = 3'd0; A = '0;
  endtask

  // Counts cycles busy is seen high; returns just after the negedge of the
  // first busy=0 cycle so a follow-up start lands in that cycle.
  task automatic wait_done(output int n, output logic [31:0] first_out);
    n = 0;
    first_out = '0;
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      if (n == 0) first_out = MDUOut;
      n++;
      if (n > 200) begin
        n_tests++; n_fail++;
        $display("FAIL busy_timeout: busy still 1 after %0d cycles", n);
        break;
      end
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          n;
    logic [31:0] fo;
    logic [64:0] r;
    reset = 1'b1; MDUOp = 3'd0; MDUStart = 1'b0; req = 1'b0; A = '0; B = '0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);

    // Pin the model to hand-computed values.
    r = model_calc(3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("model_mult_hi", r[63:32], 32'hFFFF_FFFF);
    chk("model_mult_lo", r[31:0], 32'hFFFF_FFFA);
    r = model_calc(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("model_div_lo", r[31:0], 32'hFFFF_FFFD);
    chk("model_div_hi", r[63:32], 32'hFFFF_FFFF);

    // mult -2 * 3
    start_op(3'd0, 32'hFFFF_FFFE, 32'd3, 3'd0);
    wait_done(n, fo);
    chk("mult_busy_len", n, 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    // multu same operands; mfhi during busy must show the old HI
    start_op(3'd1, 32'hFFFF_FFFE, 32'd3, 3'd7);
    wait_done(n, fo);
    chk("multu_busy_len", n, 32'd5);
    chk("multu_mfhi_during_busy", fo, 32'hFFFF_FFFF);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    // div -7 / 2, then divu 7 / 2 back-to-back in the first idle cycle
    start_op(3'd2, 32'hFFFF_FFF9, 32'd2, 3'd0);
    wait_done(n, fo);
    chk("div_busy_len", n, 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    start_op(3'd3, 32'd7, 32'd2, 3'd0);
    wait_done(n, fo);
    chk("divu_b2b_busy_len", n, 32'd10);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    // mthi/mtlo then divide by zero leaves them untouched
    mt_op(3'd5, 32'h0000_1234);
    chk("mthi_hi", HI, 32'h0000_1234);
    mt_op(3'd4, 32'h0000_5678);
    chk("mtlo_lo", LO, 32'h0000_5678);
    start_op(3'd3, 32'd99, 32'd0, 3'd0);
    wait_done(n, fo);
    chk("div0_busy_len", n, 32'd10);
    chk("div0_hi", HI, 32'h0000_1234);
    chk("div0_lo", LO, 32'h0000_5678);

    // start and mtlo while busy are both ignored
    start_op(3'd2, 32'hFFFF_FFF9, 32'd2, 3'd0);
    MDUOp = 3'd0; MDUStart = 1'b1; A = 32'd100; B = 32'd100;
    tick();
    MDUStart = 1'b0;
    mt_op(3'd4, 32'h0000_AAAA);
    wait_done(n, fo);
    chk("hazard_busy_len", n, 32'd8);
    chk("hazard_hi", HI, 32'hFFFF_FFFF);
    chk("hazard_lo", LO, 32'hFFFF_FFFD);

    // req blocks both a start and an mt write
    req = 1'b1;
    MDUOp = 3'd0; MDUStart = 1'b1; A = 32'd5; B = 32'd5;
    tick();
    MDUStart = 1'b0;
    chk("req_busy", {31'd0, busy}, 32'd0);
    mt_op(3'd4, 32'h0000_BBBB);
    req = 1'b0;
    chk("req_hi", HI, 32'hFFFF_FFFF);
    chk("req_lo", LO, 32'hFFFF_FFFD);

    // mfhi / mflo / other opcodes
    MDUOp = 3'd7; tick();
    chk("mfhi_out", MDUOut, 32'hFFFF_FFFF);
    MDUOp = 3'd6; tick();
    chk("mflo_out", MDUOut, 32'hFFFF_FFFD);
    MDUOp = 3'd2; tick();
    chk("other_out", MDUOut, 32'd0);
    MDUOp = 3'd0;

    // reset at cycle 3 of a mult aborts it
    start_op(3'd0, 32'd3, 32'd4, 3'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    tick(); tick(); tick();
    chk("abort_stays_hi", HI, 32'd0);
    chk("abort_stays_lo", LO, 32'd0);

    // unit works normally after the abort
    start_op(3'd0, 32'd3, 32'd4, 3'd0);
    wait_done(n, fo);
    chk("post_reset_busy_len", n, 32'd5);
    chk("post_reset_lo", LO, 32'd12);
    chk("post_reset_hi", HI, 32'd0);

    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
